fpu_op_sequencer: RTL and testbench
===================================

Name: fpu_op_sequencer

Overview:
Controller between the UART receiver, the floating-point arithmetic unit and the UART transmitter. It captures an operand pair and an opcode, issues one operation to the FPU over a start/done handshake, and latches the 32-bit result for the seven-segment display path. It then streams the result MSB-first as four bytes to the byte-wide transmitter, pacing each byte on tx_busy.

Parameters:
DATA_W, 32, operand/result width; must be a multiple of 8
TIMEOUT_CYC, 1024, max clk cycles spent in WAIT_FPU or TX_ACK before abort

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  synchronous active-low reset
operands_valid  in  1  one-cycle pulse from receiver: num1/num2 valid
num1  in  DATA_W  operand A
num2  in  DATA_W  operand B
operation  in  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 bypass num1, 101 bypass num2, 11x reserved (= bypass num1)
fpu_start  out  1  one-cycle issue pulse
fpu_op  out  2  operation[1:0], held from ISSUE through WAIT_FPU
fpu_a  out  DATA_W  captured num1
fpu_b  out  DATA_W  captured num2
fpu_done  in  1  one-cycle completion pulse from FPU
fpu_result  in  DATA_W  valid when fpu_done=1
result  out  DATA_W  last latched result
result_valid  out  1  one-cycle pulse when result updates
tx_data  out  8  byte to transmitter
tx_wr_en  out  1  one-cycle write request
tx_busy  in  1  transmitter busy
busy  out  1  high in every state except IDLE
overrun  out  1  sticky; set when operands_valid is dropped
err_timeout  out  1  one-cycle pulse on timeout abort

Behaviour:
- All state is updated only on posedge clk. rst_n=0 at an edge forces IDLE, clears the timer and byte index, and sets every output to 0, including result and overrun. This holds mid-operation; a transmitter frame already in flight is not tracked after reset.
- States: IDLE, ISSUE, WAIT_FPU, LOAD, TX_REQ, TX_ACK, TX_DONE.
- IDLE: on operands_valid=1, capture num1, num2 and operation. If operation[2]=0, go to ISSUE; otherwise go to LOAD with the bypass value.
- ISSUE: fpu_start=1 for exactly this one cycle, then go to WAIT_FPU. fpu_done is ignored in ISSUE.
- WAIT_FPU: on fpu_done, latch fpu_result and go to LOAD. If TIMEOUT_CYC cycles pass without done: latch 32'h7FC00000 (qNaN), pulse err_timeout, go to LOAD.
- LOAD: result_valid=1 for one cycle; result already holds the new value in this cycle. Set byte index to 0, go to TX_REQ.
- TX_REQ: wait while tx_busy=1. When tx_busy=0, drive tx_wr_en=1 for one cycle with tx_data = result[DATA_W-1-8*idx -: 8], then go to TX_ACK.
- TX_ACK: wait for tx_busy=1, then go to TX_DONE. If TIMEOUT_CYC cycles pass first: pulse err_timeout, abort the remaining bytes, go to IDLE.
- TX_DONE: wait for tx_busy=0. Then, if idx = DATA_W/8-1, go to IDLE; otherwise increment idx and go to TX_REQ.
- tx_data holds its value from TX_REQ until the next TX_REQ.
- Timer: cleared on every state entry; only counts in WAIT_FPU and TX_ACK.
- operands_valid while busy=1: the pulse is ignored, overrun is set, and captured operands are unchanged. The next accepted operands_valid clears overrun.
- operands_valid in the same cycle as the IDLE re-entry edge is not seen; it must arrive while in IDLE.
- Minimum latency for bypass: operands_valid at cycle N gives result_valid at N+1 and the first tx_wr_en at N+2 (with tx_busy=0).
- Minimum latency for FPU ops: fpu_start at N+1; fpu_done at cycle M gives result_valid at M+1.

Optional Feature:
TX_CHECKSUM_EN: when defined, a fifth byte is sent after the DATA_W/8 result bytes, using the same TX_REQ/TX_ACK/TX_DONE handshake. Its value is the XOR of all result bytes. When undefined, exactly DATA_W/8 bytes are sent and no checksum logic exists.

Test Plan:
- Add: num1=3F800000, num2=40000000, op=000; FPU model returns 40400000 after 5 cycles -> one fpu_start pulse, fpu_op=00, result=40400000, then tx bytes 40,40,00,00 in order, four tx_wr_en pulses total, each only while tx_busy=0.
- Bypass: op=101, num2=ABCE2135 -> no fpu_start; result_valid one cycle after operands_valid; bytes AB,CE,21,35. With TX_CHECKSUM_EN, a fifth byte 71.
- FPU timeout: fpu_done never asserted, TIMEOUT_CYC=16 -> err_timeout pulse 16 cycles after entering WAIT_FPU; result=7FC00000; bytes 7F,C0,00,00.
- Overrun: a second operands_valid during WAIT_FPU -> overrun=1, original operands are used; overrun clears on the next operands_valid accepted in IDLE.
- Transmitter stall: tx_busy held high for 200 cycles before byte 2 -> tx_wr_en stays 0 until tx_busy falls, then exactly one pulse; if tx_busy never rises after a write, err_timeout fires and the FSM returns to IDLE.
- Reset mid-transfer: rst_n=0 for one edge during TX_DONE of byte 1 -> next cycle busy=0, tx_wr_en=0, result=0; a new command runs normally.

Source files
------------

// File: rtl/fpu_op_sequencer_if.sv
// FPU issue/complete and byte-transmitter handshake bundle for fpu_op_sequencer.
// master = sequencer side, slave = FPU / UART transmitter side.
interface fpu_op_sequencer_if #(
    parameter int DATA_W = 32
);

    logic              fpu_start;
    logic [1:0]        fpu_op;
    logic [DATA_W-1:0] fpu_a;
    logic [DATA_W-1:0] fpu_b;
    logic              fpu_done;
    logic [DATA_W-1:0] fpu_result;

    logic [7:0]        tx_data;
    logic              tx_wr_en;
    logic              tx_busy;

    modport master (
        output fpu_start,
        output fpu_op,
        output fpu_a,
        output fpu_b,
        input  fpu_done,
        input  fpu_result,
        output tx_data,
        output tx_wr_en,
        input  tx_busy
    );

    modport slave (
        input  fpu_start,
        input  fpu_op,
        input  fpu_a,
        input  fpu_b,
        output fpu_done,
        output fpu_result,
        input  tx_data,
        input  tx_wr_en,
        output tx_busy
    );

endinterface

// File: rtl/fpu_op_sequencer.sv
// Operand capture -> FPU issue -> result latch -> MSB-first byte stream to UART tx.
// Define TX_CHECKSUM_EN to append an XOR checksum byte after the result bytes.
module fpu_op_sequencer #(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              operands_valid,
    input  logic [DATA_W-1:0] num1,
    input  logic [DATA_W-1:0] num2,
    input  logic [2:0]        operation,
    fpu_op_sequencer_if.master bus,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              busy,
    output logic              overrun,
    output logic              err_timeout
);

    localparam int NB = DATA_W / 8;
`ifdef TX_CHECKSUM_EN
    localparam int NTX = NB + 1;
`else
    localparam int NTX = NB;
`endif
    localparam int IW = $clog2(NTX + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [IW-1:0]     LAST = IW'(NTX - 1);
    localparam logic [TW-1:0]     TLIM = TW'(TIMEOUT_CYC - 1);
    localparam logic [DATA_W-1:0] QNAN = DATA_W'(32'h7FC0_0000);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_FPU,
        LOAD,
        TX_REQ,
        TX_ACK,
        TX_DONE
    } state_t;

    state_t state;
    state_t state_n;

    logic [1:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] res_q;
    logic [IW-1:0]     idx_q;
    logic [7:0]        txd_q;
    logic [TW-1:0]     tmr_q;
    logic [TW-1:0]     tmr_n;
    logic              ovr_q;
    logic              tmo_q;

    logic start_c;
    logic rv_c;
    logic wr_c;
    logic tmo_c;
    logic tmr_hit;
    logic next_byte;

    // Byte idx of the stream; idx == NB selects the checksum when enabled.
    function automatic logic [7:0] pick(
        input logic [IW-1:0]     i,
        input logic [DATA_W-1:0] v
    );
        logic [7:0] b;
        b = '0;
        for (int k = 0; k < NB; k++) begin
            if (i == IW'(k))
                b = v[DATA_W-1-8*k -: 8];
        end
`ifdef TX_CHECKSUM_EN
        if (i == IW'(NB)) begin
            for (int k = 0; k < NB; k++)
                b = b ^ v[8*k +: 8];
        end
`endif
        return b;
    endfunction

    assign tmr_hit = (tmr_q == TLIM);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        start_c   = 1'b0;
        rv_c      = 1'b0;
        wr_c      = 1'b0;
        tmo_c     = 1'b0;
        next_byte = 1'b0;
        unique case (state)
            IDLE: begin
                if (operands_valid)
                    state_n = operation[2] ? LOAD : ISSUE;
            end
            ISSUE: begin
                start_c = 1'b1;
                state_n = WAIT_FPU;
            end
            WAIT_FPU: begin
                if (bus.fpu_done) begin
                    state_n = LOAD;
                end else if (tmr_hit) begin
                    tmo_c   = 1'b1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                rv_c    = 1'b1;
                state_n = TX_REQ;
            end
            TX_REQ: begin
                if (!bus.tx_busy) begin
                    wr_c    = 1'b1;
                    state_n = TX_ACK;
                end
            end
            TX_ACK: begin
                if (bus.tx_busy) begin
                    state_n = TX_DONE;
                end else if (tmr_hit) begin
                    tmo_c   = 1'b1;
                    state_n = IDLE;
                end
            end
            TX_DONE: begin
                if (!bus.tx_busy) begin
                    if (idx_q == LAST) begin
                        state_n = IDLE;
                    end else begin
                        next_byte = 1'b1;
                        state_n   = TX_REQ;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Timer restarts on every state change and only runs while waiting.
    always_comb begin
        tmr_n = tmr_q;
        if (state_n != state)
            tmr_n = '0;
        else if (state == WAIT_FPU || state == TX_ACK)
            tmr_n = tmr_q + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            idx_q <= '0;
            txd_q <= '0;
            tmr_q <= '0;
            ovr_q <= 1'b0;
            tmo_q <= 1'b0;
        end else begin
            tmr_q <= tmr_n;
            tmo_q <= tmo_c;

            if (operands_valid) begin
                if (state == IDLE) begin
                    op_q  <= operation[1:0];
                    a_q   <= num1;
                    b_q   <= num2;
                    ovr_q <= 1'b0;
                    // Bypass ops land in result directly; 11x acts as num1.
                    if (operation[2])
                        res_q <= (operation[1:0] == 2'b01) ? num2 : num1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end

            if (state == WAIT_FPU) begin
                if (bus.fpu_done)
                    res_q <= bus.fpu_result;
                else if (tmr_hit)
                    res_q <= QNAN;
            end

            if (state == LOAD) begin
                idx_q <= '0;
                txd_q <= pick('0, res_q);
            end

            if (next_byte) begin
                idx_q <= idx_q + IW'(1);
                txd_q <= pick(idx_q + IW'(1), res_q);
            end
        end
    end

    assign bus.fpu_start = start_c;
    assign bus.fpu_op    = op_q;
    assign bus.fpu_a     = a_q;
    assign bus.fpu_b     = b_q;
    assign bus.tx_data   = txd_q;
    assign bus.tx_wr_en  = wr_c;

    assign result        = res_q;
    assign result_valid  = rv_c;
    assign busy          = (state != IDLE);
    assign overrun       = ovr_q;
    assign err_timeout   = tmo_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer with FPU and UART transmitter models.
// TIMEOUT_CYC is reduced to 16 so the abort paths are reached quickly.
module tb_fpu_op_sequencer;

    localparam int DW = 32;
    localparam int TO = 16;
`ifdef TX_CHECKSUM_EN
    localparam int NTX = 5;
`else
    localparam int NTX = 4;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          operands_valid = 1'b0;
    logic [DW-1:0] num1 = '0;
    logic [DW-1:0] num2 = '0;
    logic [2:0]    operation = '0;
    logic [DW-1:0] result;
    logic          result_valid;
    logic          busy;
    logic          overrun;
    logic          err_timeout;

    int checks = 0;
    int errors = 0;

    // FPU model
    bit            fpu_en = 1'b0;
    int            fpu_lat = 5;
    logic [DW-1:0] fpu_res = '0;
    int            fcnt = 0;
    int            starts = 0;

    // Transmitter model
    bit         stall = 1'b0;
    bit         mute = 1'b0;
    int         mcnt = 0;
    int         wr_busy_err = 0;
    logic [7:0] wr_q[$];

    fpu_op_sequencer_if #(.DATA_W(DW)) bus ();

    fpu_op_sequencer #(
        .DATA_W(DW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .operands_valid(operands_valid),
        .num1(num1),
        .num2(num2),
        .operation(operation),
        .bus(bus),
        .result(result),
        .result_valid(result_valid),
        .busy(busy),
        .overrun(overrun),
        .err_timeout(err_timeout)
    );

    always #10 clk = ~clk;

    assign bus.fpu_done   = (fcnt == 1);
    assign bus.fpu_result = fpu_res;
    assign bus.tx_busy    = (mcnt > 0) || stall;

    always @(posedge clk) begin
        if (bus.fpu_start) begin
            starts <= starts + 1;
            if (fpu_en)
                fcnt <= fpu_lat;
        end else if (fcnt > 0) begin
            fcnt <= fcnt - 1;
        end
    end

    always @(posedge clk) begin
        if (bus.tx_wr_en) begin
            wr_q.push_back(bus.tx_data);
            if (bus.tx_busy)
                wr_busy_err <= wr_busy_err + 1;
            if (!mute)
                mcnt <= 3;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(
        input string       tag,
        input logic [63:0] obs,
        input logic [63:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b,
        input logic [2:0]    op
    );
        operands_valid = 1'b1;
        num1 = a;
        num2 = b;
        operation = op;
        tick();
        operands_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(busy), 64'd0);
    endtask

    task automatic wait_rv(input string tag, input int budget);
        int n = 0;
        while (!result_valid && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(result_valid), 64'd1);
    endtask

    task automatic wait_wr(input string tag, input int cnt, input int budget);
        int n = 0;
        while (wr_q.size() < cnt && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(wr_q.size()), 64'(cnt));
    endtask

    task automatic chk_tx(input string tag, input logic [31:0] w);
        logic [7:0] e[5];
        logic [7:0] x;
        logic [7:0] got;
        x = '0;
        for (int i = 0; i < 4; i++) begin
            e[i] = w[31-8*i -: 8];
            x = x ^ e[i];
        end
        e[4] = x;
        chk({tag, "_cnt"}, 64'(wr_q.size()), 64'(NTX));
        for (int i = 0; i < NTX; i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 8'hxx;
            chk($sformatf("%s_b%0d", tag, i), 64'(got), 64'(e[i]));
        end
        chk({tag, "_wr_busy"}, 64'(wr_busy_err), 64'd0);
    endtask

    initial begin
        int s0;

        // Reset
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_rv", 64'(result_valid), 64'd0);
        chk("rst_wr", 64'(bus.tx_wr_en), 64'd0);
        chk("rst_start", 64'(bus.fpu_start), 64'd0);
        chk("rst_ovr", 64'(overrun), 64'd0);
        chk("rst_tmo", 64'(err_timeout), 64'd0);
        rst_n = 1'b1;
        tick();

        // Add: 1.0 + 2.0 = 3.0, FPU answers after 5 cycles
        fpu_en = 1'b1;
        fpu_lat = 5;
        fpu_res = 32'h4040_0000;
        wr_q.delete();
        s0 = starts;
        send(32'h3F80_0000, 32'h4000_0000, 3'b000);
        chk("add_start", 64'(bus.fpu_start), 64'd1);
        chk("add_op", 64'(bus.fpu_op), 64'd0);
        chk("add_a", 64'(bus.fpu_a), 64'h3F80_0000);
        chk("add_b", 64'(bus.fpu_b), 64'h4000_0000);
        chk("add_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("add_start_lo", 64'(bus.fpu_start), 64'd0);
        end
        chk("add_rv_early", 64'(result_valid), 64'd0);
        tick();
        chk("add_rv", 64'(result_valid), 64'd1);
        chk("add_res", 64'(result), 64'h4040_0000);
        tick();
        chk("add_rv_pulse", 64'(result_valid), 64'd0);
        wait_idle("add_idle", 200);
        chk("add_nstart", 64'(starts - s0), 64'd1);
        chk_tx("add_tx", 32'h4040_0000);

        // Bypass num2
        wr_q.delete();
        s0 = starts;
        send(32'h1111_1111, 32'hABCE_2135, 3'b101);
        chk("byp_rv", 64'(result_valid), 64'd1);
        chk("byp_res", 64'(result), 64'hABCE_2135);
        tick();
        chk("byp_wr", 64'(bus.tx_wr_en), 64'd1);
        chk("byp_data", 64'(bus.tx_data), 64'hAB);
        wait_idle("byp_idle", 200);
        chk("byp_nstart", 64'(starts - s0), 64'd0);
        chk_tx("byp_tx", 32'hABCE_2135);

        // FPU never answers: qNaN after 16 cycles in WAIT_FPU
        fpu_en = 1'b0;
        wr_q.delete();
        send(32'h4000_0000, 32'h4000_0000, 3'b010);
        chk("tmo_start", 64'(bus.fpu_start), 64'd1);
        chk("tmo_op", 64'(bus.fpu_op), 64'd2);
        for (int i = 0; i < 16; i++)
            tick();
        chk("tmo_early", 64'(err_timeout), 64'd0);
        tick();
        chk("tmo_pulse", 64'(err_timeout), 64'd1);
        chk("tmo_rv", 64'(result_valid), 64'd1);
        chk("tmo_res", 64'(result), 64'h7FC0_0000);
        tick();
        chk("tmo_pulse_end", 64'(err_timeout), 64'd0);
        wait_idle("tmo_idle", 200);
        chk_tx("tmo_tx", 32'h7FC0_0000);

        // Overrun during WAIT_FPU keeps the first operands
        fpu_en = 1'b1;
        fpu_res = 32'h1234_5678;
        wr_q.delete();
        send(32'h40A0_0000, 32'h4040_0000, 3'b001);
        tick();
        send(32'hDEAD_BEEF, 32'hCAFE_BABE, 3'b000);
        chk("ovr_set", 64'(overrun), 64'd1);
        chk("ovr_a", 64'(bus.fpu_a), 64'h40A0_0000);
        chk("ovr_b", 64'(bus.fpu_b), 64'h4040_0000);
        chk("ovr_op", 64'(bus.fpu_op), 64'd1);
        wait_rv("ovr_rv", 20);
        chk("ovr_res", 64'(result), 64'h1234_5678);
        wait_idle("ovr_idle", 200);
        chk("ovr_sticky", 64'(overrun), 64'd1);
        chk_tx("ovr_tx", 32'h1234_5678);
        wr_q.delete();
        send(32'h0102_0304, 32'h0, 3'b100);
        chk("ovr_clr", 64'(overrun), 64'd0);
        chk("ovr_res2", 64'(result), 64'h0102_0304);
        wait_idle("ovr_idle2", 200);
        chk_tx("ovr_tx2", 32'h0102_0304);

        // Transmitter stalls for 200 cycles before the second byte
        wr_q.delete();
        send(32'hCAFE_F00D, 32'h0, 3'b110);
        wait_wr("stl_first", 1, 20);
        stall = 1'b1;
        for (int i = 0; i < 200; i++)
            tick();
        chk("stl_hold", 64'(wr_q.size()), 64'd1);
        chk("stl_busy", 64'(busy), 64'd1);
        stall = 1'b0;
        wait_idle("stl_idle", 200);
        chk_tx("stl_tx", 32'hCAFE_F00D);

        // Transmitter never goes busy after a write: TX_ACK timeout
        mute = 1'b1;
        wr_q.delete();
        send(32'h55AA_55AA, 32'h0, 3'b100);
        tick();
        chk("mut_wr", 64'(bus.tx_wr_en), 64'd1);
        for (int i = 0; i < 16; i++)
            tick();
        chk("mut_early", 64'(err_timeout), 64'd0);
        chk("mut_busy", 64'(busy), 64'd1);
        tick();
        chk("mut_tmo", 64'(err_timeout), 64'd1);
        chk("mut_idle", 64'(busy), 64'd0);
        chk("mut_nwr", 64'(wr_q.size()), 64'd1);
        mute = 1'b0;
        tick();

        // Reset while waiting on the first byte's TX_DONE
        wr_q.delete();
        send(32'h89AB_CDEF, 32'h0, 3'b100);
        wait_wr("rmt_first", 1, 20);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rmt_busy", 64'(busy), 64'd0);
        chk("rmt_wr", 64'(bus.tx_wr_en), 64'd0);
        chk("rmt_res", 64'(result), 64'd0);
        chk("rmt_nwr", 64'(wr_q.size()), 64'd1);
        for (int i = 0; i < 5; i++)
            tick();
        wr_q.delete();
        fpu_res = 32'h3F80_0000;
        send(32'h3F00_0000, 32'h3F00_0000, 3'b000);
        chk("rmt_start", 64'(bus.fpu_start), 64'd1);
        wait_rv("rmt_rv", 20);
        chk("rmt_res2", 64'(result), 64'h3F80_0000);
        wait_idle("rmt_idle", 200);
        chk_tx("rmt_tx", 32'h3F80_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
